// File: rtl/cache_sa_engine_if.sv
// Request/response and statistics bundle for cache_sa_engine.
// The trace bench is the master; the engine is the slave.
interface cache_sa_engine_if #(
   parameter int ADDR_W = 48,
   parameter int TAG_W  = 38,
   parameter int CNT_W  = 16
);
   logic              req_valid;
   logic              req_ready;
   logic [7:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic              resp_valid;
   logic              resp_hit;
   logic              resp_err;
   logic [TAG_W-1:0]  resp_tag;
   logic [CNT_W-1:0]  num_reads;
   logic [CNT_W-1:0]  num_writes;
   logic [CNT_W-1:0]  num_hits;
   logic [CNT_W-1:0]  num_misses;
   logic [CNT_W-1:0]  num_writebacks;
   logic [CNT_W-1:0]  num_mem_writes;

   modport master (
      output req_valid, req_op, req_addr,
      input  req_ready, resp_valid, resp_hit, resp_err, resp_tag,
      input  num_reads, num_writes, num_hits, num_misses, num_writebacks, num_mem_writes
   );

   modport slave (
      input  req_valid, req_op, req_addr,
      output req_ready, resp_valid, resp_hit, resp_err, resp_tag,
      output num_reads, num_writes, num_hits, num_misses, num_writebacks, num_mem_writes
   );
endinterface

// File: rtl/cache_sa_engine.sv
// Set-associative tag/stat engine: one request per two cycles, WBWA/WTNA write
// policies, LRU/FIFO replacement, saturating statistics counters.
module cache_sa_way #(
   parameter int TAG_W = 38
) (
   input  logic             valid,
   input  logic [TAG_W-1:0] tag,
   input  logic [TAG_W-1:0] req_tag,
   output logic             hit
);
   assign hit = valid && (tag == req_tag);
endmodule

module cache_sa_engine #(
   parameter int ADDR_W      = 48,
   parameter int BLOCK_BYTES = 64,
   parameter int NUM_SETS    = 16,
   parameter int ASSOC       = 4,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               write_policy,
   input  logic               replace_policy,
   cache_sa_engine_if.slave   bus
);
   localparam int OFF_W  = $clog2(BLOCK_BYTES);
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int LINE_W = ADDR_W - OFF_W;
   localparam int WAY_W  = $clog2(ASSOC);
   localparam int AGE_W  = WAY_W;
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(ASSOC - 1);
   localparam logic [7:0] OP_R = 8'h52;
   localparam logic [7:0] OP_W = 8'h57;

   typedef enum logic {IDLE, LOOKUP} state_t;
   state_t state, state_nxt;

   logic              wt_mode, fifo_mode;
   logic [7:0]        op_q;
   logic [LINE_W-1:0] line_q;

   logic [TAG_W-1:0]                 tag_mem   [NUM_SETS][ASSOC];
   logic [AGE_W-1:0]                 age_mem   [NUM_SETS][ASSOC];
   logic [WAY_W-1:0]                 fifo_ptr  [NUM_SETS];
   logic [NUM_SETS-1:0][ASSOC-1:0]   valid_mem, dirty_mem;

   logic             resp_valid, resp_hit, resp_err;
   logic [TAG_W-1:0] resp_tag;
   logic [CNT_W-1:0] cnt_rd, cnt_wr, cnt_hit, cnt_miss, cnt_wb, cnt_mw;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             is_rd, is_wr, legal, accept;
   logic [ASSOC-1:0] hit_vec;
   logic             hit, inv_found, alloc, touch, evict_dirty, mem_wr;
   logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim, way_sel;
   logic [AGE_W-1:0] ref_age;
   logic             unused_off;

   assign unused_off = ^bus.req_addr[OFF_W-1:0];

   assign idx    = line_q[IDX_W-1:0];
   assign tag    = line_q[LINE_W-1:IDX_W];
   assign is_rd  = (op_q == OP_R);
   assign is_wr  = (op_q == OP_W);
   assign legal  = is_rd || is_wr;
   assign accept = bus.req_valid && (state == IDLE);

   for (genvar w = 0; w < ASSOC; w++) begin : g_way
      cache_sa_way #(.TAG_W(TAG_W)) u_way (
         .valid   (valid_mem[idx][w]),
         .tag     (tag_mem[idx][w]),
         .req_tag (tag),
         .hit     (hit_vec[w])
      );
   end

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      lru_way   = '0;
      for (int w = 0; w < ASSOC; w++) begin
         if (hit_vec[w] && !hit) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_mem[idx][w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      for (int w = 1; w < ASSOC; w++)
         if (age_mem[idx][w] > age_mem[idx][lru_way]) lru_way = WAY_W'(w);
      victim      = inv_found ? inv_way : (fifo_mode ? fifo_ptr[idx] : lru_way);
      alloc       = legal && !hit && (is_rd || !wt_mode);
      touch       = legal && (hit || alloc);
      way_sel     = hit ? hit_way : victim;
      // A fill behaves as if the incoming line were the oldest, so every other way ages
      ref_age     = hit ? age_mem[idx][hit_way] : AGE_MAX;
      evict_dirty = alloc && valid_mem[idx][victim] && dirty_mem[idx][victim];
      mem_wr      = evict_dirty || (is_wr && wt_mode);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.req_valid) state_nxt = LOOKUP;
         LOOKUP:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         wt_mode    <= write_policy;
         fifo_mode  <= replace_policy;
         op_q       <= '0;
         line_q     <= '0;
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_err   <= 1'b0;
         resp_tag   <= '0;
         cnt_rd     <= '0;
         cnt_wr     <= '0;
         cnt_hit    <= '0;
         cnt_miss   <= '0;
         cnt_wb     <= '0;
         cnt_mw     <= '0;
         valid_mem  <= '0;
         dirty_mem  <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            fifo_ptr[s] <= '0;
            for (int w = 0; w < ASSOC; w++) age_mem[s][w] <= '0;
         end
      end else begin
         resp_valid <= 1'b0;
         if (accept) begin
            op_q   <= bus.req_op;
            line_q <= bus.req_addr[ADDR_W-1:OFF_W];
         end
         if (state == LOOKUP) begin
            resp_valid <= 1'b1;
            resp_tag   <= tag;
            resp_err   <= !legal;
            resp_hit   <= legal && hit;
            if (legal) begin
               if (is_rd)       cnt_rd   <= sat_inc(cnt_rd);
               if (is_wr)       cnt_wr   <= sat_inc(cnt_wr);
               if (hit)         cnt_hit  <= sat_inc(cnt_hit);
               else             cnt_miss <= sat_inc(cnt_miss);
               if (evict_dirty) cnt_wb   <= sat_inc(cnt_wb);
               if (mem_wr)      cnt_mw   <= sat_inc(cnt_mw);
            end
            if (touch && !fifo_mode) begin
               for (int w = 0; w < ASSOC; w++) begin
                  if (WAY_W'(w) == way_sel)          age_mem[idx][w] <= '0;
                  else if (age_mem[idx][w] < ref_age) age_mem[idx][w] <= age_mem[idx][w] + 1'b1;
               end
            end
            if (alloc) begin
               valid_mem[idx][way_sel] <= 1'b1;
               dirty_mem[idx][way_sel] <= is_wr;
               fifo_ptr[idx]           <= fifo_ptr[idx] + 1'b1;
            end else if (hit && is_wr && !wt_mode) begin
               dirty_mem[idx][way_sel] <= 1'b1;
            end
         end
      end
   end

   // Tags need no reset: a way is only looked at once its valid bit is set
   always_ff @(posedge clk) begin
      if (!reset && (state == LOOKUP) && alloc) tag_mem[idx][way_sel] <= tag;
   end

   assign bus.req_ready      = (state == IDLE);
   assign bus.resp_valid     = resp_valid;
   assign bus.resp_hit       = resp_hit;
   assign bus.resp_err       = resp_err;
   assign bus.resp_tag       = resp_tag;
   assign bus.num_reads      = cnt_rd;
   assign bus.num_writes     = cnt_wr;
   assign bus.num_hits       = cnt_hit;
   assign bus.num_misses     = cnt_miss;
   assign bus.num_writebacks = cnt_wb;
   assign bus.num_mem_writes = cnt_mw;
endmodule

// File: tb/tb_cache_sa_engine.sv
// Directed bench for cache_sa_engine: a per-set ordered-list cache model predicts every
// response, plus literal expectations for the reference scenarios.
module tb_cache_sa_engine;
   localparam int ADDR_W   = 48;
   localparam int OFF_W    = 6;
   localparam int IDX_W    = 4;
   localparam int NUM_SETS = 16;
   localparam int ASSOC    = 4;
   localparam int TAG_W    = ADDR_W - IDX_W - OFF_W;
   localparam logic [7:0] OP_R = 8'h52;
   localparam logic [7:0] OP_W = 8'h57;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic write_policy = 1'b0;
   logic replace_policy = 1'b0;
   always #5 clk = ~clk;

   cache_sa_engine_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .CNT_W(16)) bus ();
   cache_sa_engine_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .CNT_W(4))  bus4 ();

   cache_sa_engine #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .write_policy(write_policy),
      .replace_policy(replace_policy), .bus(bus)
   );
   cache_sa_engine #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .write_policy(write_policy),
      .replace_policy(replace_policy), .bus(bus4)
   );

   typedef struct {
      bit               hit;
      bit               err;
      logic [TAG_W-1:0] tag;
      int               due, rd, wr, ht, ms, wb, mw;
   } exp_t;

   exp_t exp_q[$];
   int n_chk = 0, n_pass = 0, cyc = 0, hs_cyc = 0;
   bit last_hit, last_err;
   logic [TAG_W-1:0] last_tag;

   // Model: per set an ordered list of resident lines, oldest first
   logic [TAG_W-1:0] mtag   [NUM_SETS][ASSOC];
   bit               mdirty [NUM_SETS][ASSOC];
   int               mcnt   [NUM_SETS];
   int m_rd, m_wr, m_ht, m_ms, m_wb, m_mw;
   bit m_wt, m_fifo;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int sat(input int v, input int w);
      int m = (1 << w) - 1;
      return (v > m) ? m : v;
   endfunction

   task automatic model_clear(input bit wp, input bit rp);
      for (int s = 0; s < NUM_SETS; s++) mcnt[s] = 0;
      m_rd = 0; m_wr = 0; m_ht = 0; m_ms = 0; m_wb = 0; m_mw = 0;
      m_wt = wp; m_fifo = rp;
   endtask

   task automatic lru_touch(input int s, input int pos);
      logic [TAG_W-1:0] t = mtag[s][pos];
      bit d = mdirty[s][pos];
      for (int i = pos; i < mcnt[s] - 1; i++) begin
         mtag[s][i] = mtag[s][i+1];
         mdirty[s][i] = mdirty[s][i+1];
      end
      mtag[s][mcnt[s]-1] = t;
      mdirty[s][mcnt[s]-1] = d;
   endtask

   task automatic line_fill(input int s, input logic [TAG_W-1:0] t, input bit d);
      if (mcnt[s] == ASSOC) begin
         if (mdirty[s][0]) begin m_wb++; m_mw++; end
         for (int i = 0; i < ASSOC - 1; i++) begin
            mtag[s][i] = mtag[s][i+1];
            mdirty[s][i] = mdirty[s][i+1];
         end
         mcnt[s]--;
      end
      mtag[s][mcnt[s]] = t;
      mdirty[s][mcnt[s]] = d;
      mcnt[s]++;
   endtask

   task automatic model_apply(input logic [7:0] op, input logic [ADDR_W-1:0] a, input int due);
      exp_t e;
      int s = int'(a[OFF_W+IDX_W-1:OFF_W]);
      int pos = -1;
      bit isw = (op == OP_W);
      e.tag = a[ADDR_W-1:OFF_W+IDX_W];
      e.hit = 1'b0;
      e.err = !(isw || op == OP_R);
      e.due = due;
      if (!e.err) begin
         for (int i = 0; i < mcnt[s]; i++) if (mtag[s][i] == e.tag) pos = i;
         if (isw) m_wr++; else m_rd++;
         if (isw && m_wt) m_mw++;
         if (pos >= 0) begin
            m_ht++;
            e.hit = 1'b1;
            if (isw && !m_wt) mdirty[s][pos] = 1'b1;
            if (!m_fifo) lru_touch(s, pos);
         end else begin
            m_ms++;
            if (!isw || !m_wt) line_fill(s, e.tag, isw);
         end
      end
      e.rd = m_rd; e.wr = m_wr; e.ht = m_ht; e.ms = m_ms; e.wb = m_wb; e.mw = m_mw;
      exp_q.push_back(e);
   endtask

   // Compare process: resp_valid must pulse exactly when a response is due
   always @(negedge clk) begin
      if (!reset) begin
         bit due_now;
         exp_t e;
         due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         chk("resp_valid", 64'(bus.resp_valid), 64'(due_now));
         chk("resp_valid_c4", 64'(bus4.resp_valid), 64'(due_now));
         if (due_now) begin
            e = exp_q.pop_front();
            chk("resp_hit", 64'(bus.resp_hit), 64'(e.hit));
            chk("resp_err", 64'(bus.resp_err), 64'(e.err));
            chk("resp_tag", 64'(bus.resp_tag), 64'(e.tag));
            chk("num_reads", 64'(bus.num_reads), 64'(sat(e.rd, 16)));
            chk("num_writes", 64'(bus.num_writes), 64'(sat(e.wr, 16)));
            chk("num_hits", 64'(bus.num_hits), 64'(sat(e.ht, 16)));
            chk("num_misses", 64'(bus.num_misses), 64'(sat(e.ms, 16)));
            chk("num_writebacks", 64'(bus.num_writebacks), 64'(sat(e.wb, 16)));
            chk("num_mem_writes", 64'(bus.num_mem_writes), 64'(sat(e.mw, 16)));
            chk("c4_reads", 64'(bus4.num_reads), 64'(sat(e.rd, 4)));
            chk("c4_hits", 64'(bus4.num_hits), 64'(sat(e.ht, 4)));
            chk("c4_misses", 64'(bus4.num_misses), 64'(sat(e.ms, 4)));
            last_hit = bus.resp_hit;
            last_err = bus.resp_err;
            last_tag = bus.resp_tag;
         end
      end
   end

   task automatic drive(input bit v, input logic [7:0] op, input logic [ADDR_W-1:0] a);
      bus.req_valid = v;  bus.req_op = op;  bus.req_addr = a;
      bus4.req_valid = v; bus4.req_op = op; bus4.req_addr = a;
   endtask

   task automatic do_reset(input bit wp, input bit rp);
      reset = 1'b1;
      write_policy = wp;
      replace_policy = rp;
      drive(1'b0, 8'h00, '0);
      exp_q.delete();
      model_clear(wp, rp);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic issue(input logic [7:0] op, input logic [ADDR_W-1:0] a);
      int n = 0;
      @(negedge clk);
      drive(1'b1, op, a);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 64'(bus.req_ready), 64'd1);
      hs_cyc = cyc;
      model_apply(op, a, cyc + 2);
      @(posedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic req(input logic [7:0] op, input logic [ADDR_W-1:0] a);
      issue(op, a);
      @(negedge clk);
      drive(1'b0, 8'h00, '0);
      drain();
   endtask

   logic [ADDR_W-1:0] seq2 [6];
   logic [ADDR_W-1:0] seq5 [4];
   int prev;

   initial begin
      seq2 = '{48'h000, 48'h400, 48'h800, 48'hC00, 48'h000, 48'h1000};
      seq5 = '{48'h000, 48'h040, 48'h000, 48'h080};
      drive(1'b0, 8'h00, '0);

      // 1: reset state, then miss followed by a same-line hit
      do_reset(1'b0, 1'b0);
      chk("rst_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
      chk("rst_reads", 64'(bus.num_reads), 64'd0);
      chk("rst_mem_writes", 64'(bus.num_mem_writes), 64'd0);
      req(OP_R, 48'h7fff493822b8);
      chk("t1_first_hit", 64'(last_hit), 64'd0);
      chk("t1_tag", 64'(last_tag), 64'h1FFFD24E08);
      req(OP_R, 48'h7fff493822b0);
      chk("t1_second_hit", 64'(last_hit), 64'd1);
      chk("t1_reads", 64'(bus.num_reads), 64'd2);
      chk("t1_hits", 64'(bus.num_hits), 64'd1);
      chk("t1_misses", 64'(bus.num_misses), 64'd1);

      // 2: LRU keeps the re-touched line, FIFO evicts it
      @(negedge clk);
      do_reset(1'b0, 1'b0);
      foreach (seq2[i]) req(OP_R, seq2[i]);
      req(OP_R, 48'h400);
      chk("t2_lru_400", 64'(last_hit), 64'd0);
      req(OP_R, 48'h000);
      chk("t2_lru_000", 64'(last_hit), 64'd1);
      chk("t2_lru_hits", 64'(bus.num_hits), 64'd2);
      @(negedge clk);
      do_reset(1'b0, 1'b1);
      foreach (seq2[i]) req(OP_R, seq2[i]);
      req(OP_R, 48'h400);
      chk("t2_fifo_400", 64'(last_hit), 64'd1);
      req(OP_R, 48'h000);
      chk("t2_fifo_000", 64'(last_hit), 64'd0);
      chk("t2_fifo_misses", 64'(bus.num_misses), 64'd6);

      // 3: write-back dirty eviction
      @(negedge clk);
      do_reset(1'b0, 1'b0);
      req(OP_W, 48'h000);
      req(OP_R, 48'h400);
      req(OP_R, 48'h800);
      req(OP_R, 48'hC00);
      req(OP_R, 48'h1000);
      chk("t3_writebacks", 64'(bus.num_writebacks), 64'd1);
      chk("t3_mem_writes", 64'(bus.num_mem_writes), 64'd1);
      chk("t3_writes", 64'(bus.num_writes), 64'd1);

      // 4: write-through, no write allocate
      @(negedge clk);
      do_reset(1'b1, 1'b0);
      req(OP_W, 48'h040);
      req(OP_R, 48'h040);
      chk("t4_read_hit", 64'(last_hit), 64'd0);
      chk("t4_mem_writes", 64'(bus.num_mem_writes), 64'd1);
      chk("t4_writebacks", 64'(bus.num_writebacks), 64'd0);
      chk("t4_misses", 64'(bus.num_misses), 64'd2);
      req(OP_W, 48'h040);
      chk("t4_write_hit", 64'(last_hit), 64'd1);
      chk("t4_mem_writes2", 64'(bus.num_mem_writes), 64'd2);

      // 5: back-to-back throughput, illegal op, valid pulse with no handshake
      @(negedge clk);
      do_reset(1'b0, 1'b0);
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         issue(OP_R, seq5[i]);
         if (i > 0) chk("t5_spacing", 64'(hs_cyc - prev), 64'd2);
         prev = hs_cyc;
      end
      @(negedge clk);
      drive(1'b0, 8'h00, '0);
      drain();
      issue(8'h00, 48'h123440);
      @(negedge clk);
      chk("t5_in_lookup", 64'(bus.req_ready), 64'd0);
      drive(1'b1, OP_R, 48'h040);
      @(posedge clk);
      #1 drive(1'b0, 8'h00, '0);
      drain();
      repeat (3) @(negedge clk);
      chk("t5_err", 64'(last_err), 64'd1);
      chk("t5_err_hit", 64'(last_hit), 64'd0);
      chk("t5_reads", 64'(bus.num_reads), 64'd4);
      chk("t5_hits", 64'(bus.num_hits), 64'd1);
      chk("t5_misses", 64'(bus.num_misses), 64'd3);

      // 6: reset while in LOOKUP drops the request; narrow counters saturate
      @(negedge clk);
      do_reset(1'b0, 1'b0);
      issue(OP_R, 48'h000);
      @(negedge clk);
      chk("t6_in_lookup", 64'(bus.req_ready), 64'd0);
      do_reset(1'b0, 1'b0);
      repeat (4) @(negedge clk);
      chk("t6_reads", 64'(bus.num_reads), 64'd0);
      chk("t6_misses", 64'(bus.num_misses), 64'd0);
      for (int i = 0; i < 20; i++) req(OP_R, 48'h000);
      chk("t6_reads16", 64'(bus.num_reads), 64'd20);
      chk("t6_reads4", 64'(bus4.num_reads), 64'd15);
      chk("t6_hits4", 64'(bus4.num_hits), 64'd15);
      chk("t6_misses4", 64'(bus4.num_misses), 64'd1);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
